conv_engine_seq: RTL and testbench
==================================

Name: conv_engine_seq

Overview:
- Sequential, parametrised successor to the combinational convolution unit.
- Computes a valid-mode (no padding) 2-D convolution of an up-to MAX_M x MAX_M unsigned image with an up-to MAX_K x MAX_K unsigned kernel.
- Uses one multiply-accumulate (MAC) per clock.
- Adds a start/busy/valid handshake, a real cycle counter, an error flag and a selectable wrap/saturate output mode.
- Sits in the matrix-ops datapath and is driven by the same packed matrix buses as the other matrix units.

Parameters:
- MAX_M, 5, maximum image rows/cols.
- MAX_K, 3, maximum kernel rows/cols.
- DW, 8, element width (unsigned).
- ACC_W, 20, accumulator width; must be >= 2*DW + clog2(MAX_K*MAX_K).
- DIM_W, clog2(MAX_M+1), image-dimension field width (derived).
- KDIM_W, clog2(MAX_K+1), kernel-dimension field width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- in_m  in  DIM_W  image rows.
- in_n  in  DIM_W  image cols.
- k_m  in  KDIM_W  kernel rows.
- k_n  in  KDIM_W  kernel cols.
- sat_mode  in  1  0 = wrap to DW bits, 1 = saturate to 2^DW-1.
- matrices_in  in  MAX_M*MAX_M*DW  image, row-major; element (r,c) at [(r*MAX_M+c)*DW +: DW].
- kernelMatrix  in  MAX_K*MAX_K*DW  kernel, row-major; element (r,c) at [(r*MAX_K+c)*DW +: DW].
- out_m  out  DIM_W  result rows.
- out_n  out  DIM_W  result cols.
- matrices_out  out  MAX_M*MAX_M*DW  result, same packing as matrices_in.
- busy  out  1  computation in progress.
- valid  out  1  result held and valid.
- error  out  1  one-cycle pulse on rejected dimensions.
- cycleCount  out  16  MAC cycles used by the last accepted job.

Behaviour:
- Reset: state IDLE; every output, register and accumulator is 0. Reset mid-operation aborts the job immediately; no partial result is kept.
- States: IDLE, COMPUTE. No other states.
- IDLE with start=1 (accept edge T):
  - Latch all inputs, including sat_mode, into internal registers.
  - Clear matrices_out, valid and cycleCount.
  - Dimensions are invalid if any of: in_m, in_n, k_m or k_n is 0; in_m > MAX_M; in_n > MAX_M; k_m > MAX_K; k_n > MAX_K; in_m < k_m; in_n < k_n.
  - Invalid dimensions: error=1 for cycle T+1 only; out_m = out_n = 0; valid stays 0; state stays IDLE.
  - Valid dimensions: out_m = in_m-k_m+1 and out_n = in_n-k_n+1 registered at T+1; busy=1 from T+1; enter COMPUTE.
- COMPUTE:
  - Nested counters, outer to inner: i (row), j (col), ki, kj. Only active taps are visited (ki<k_m, kj<k_n).
  - Each cycle: acc += img(i+ki, j+kj) * ker(ki, kj), full ACC_W width, unsigned; cycleCount increments by 1.
  - On the last tap of an output, element (i,j) is written that same cycle from acc+product:
    - sat_mode=0: low DW bits.
    - sat_mode=1: the full sum if < 2^DW, else 2^DW-1.
  - acc is cleared for the next element.
- Total COMPUTE cycles N = out_m*out_n*k_m*k_n. On edge T+N+1: busy=0, valid=1, state IDLE, cycleCount = N.
- valid and matrices_out hold until the next accepted start or reset. Elements outside out_m x out_n are always 0.
- start while busy is ignored; it is not queued.
- Input buses may change after acceptance without effect on the running job.
- Latched inputs are always used, never live ports.

Test Plan:
- 5x5 image of all 1s, 3x3 kernel of all 1s, sat_mode=0, start at T:
  - busy high T+1..T+81.
  - At T+82: valid=1, out_m=out_n=3, all nine outputs 9, cycleCount=81.
- 2x2 image of all 200s, 1x1 kernel of 2:
  - sat_mode=0: outputs 144, cycleCount=4.
  - Rerun with sat_mode=1: outputs 255.
- Non-square job, 4x3 image with element (r,c) = r*3+c, 2x2 kernel [1,0;0,1]:
  - out_m=3, out_n=2, cycleCount=24.
  - Outputs 4,6,10,12,16,18 row-major; all other elements 0.
- Invalid dimensions (k_m=2, in_m=1, then in_m=6):
  - error pulses exactly one cycle each time.
  - valid=0, busy never rises, matrices_out=0.
- start reasserted mid-COMPUTE with different dimensions: ignored; original job finishes with its original N and result.
- reset asserted mid-COMPUTE:
  - Next cycle: all outputs 0, state IDLE.
  - A subsequent valid start completes correctly.

Source files
------------

// File: rtl/conv_engine_seq.sv
// Sequential valid-mode 2-D convolution engine, one MAC per clock.
// Latches a job on start, walks i/j/ki/kj taps, writes each output on its last tap.
module conv_engine_seq #(
  parameter  int MAX_M  = 5,
  parameter  int MAX_K  = 3,
  parameter  int DW     = 8,
  parameter  int ACC_W  = 20,
  localparam int DIM_W  = $clog2(MAX_M + 1),
  localparam int KDIM_W = $clog2(MAX_K + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DIM_W-1:0]          in_m,
  input  logic [DIM_W-1:0]          in_n,
  input  logic [KDIM_W-1:0]         k_m,
  input  logic [KDIM_W-1:0]         k_n,
  input  logic                      sat_mode,
  input  logic [MAX_M*MAX_M*DW-1:0] matrices_in,
  input  logic [MAX_K*MAX_K*DW-1:0] kernelMatrix,
  output logic [DIM_W-1:0]          out_m,
  output logic [DIM_W-1:0]          out_n,
  output logic [MAX_M*MAX_M*DW-1:0] matrices_out,
  output logic                      busy,
  output logic                      valid,
  output logic                      error,
  output logic [15:0]               cycleCount
);

  localparam int IW = MAX_M * MAX_M * DW;
  localparam int KW = MAX_K * MAX_K * DW;
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << DW) - 1);

  typedef enum logic {
    IDLE,
    COMPUTE
  } state_t;

  state_t              state;
  logic [IW-1:0]       img_r;
  logic [KW-1:0]       ker_r;
  logic [KDIM_W-1:0]   km_r;
  logic [KDIM_W-1:0]   kn_r;
  logic                sat_r;
  logic [DIM_W-1:0]    i_r;
  logic [DIM_W-1:0]    j_r;
  logic [KDIM_W-1:0]   ki_r;
  logic [KDIM_W-1:0]   kj_r;
  logic [ACC_W-1:0]    acc;

  logic                dims_ok;
  logic [DW-1:0]       px;
  logic [DW-1:0]       kx;
  logic [2*DW-1:0]     prod;
  logic [ACC_W-1:0]    sum;
  logic [DW-1:0]       res;
  logic                last_kj;
  logic                last_ki;
  logic                last_j;
  logic                last_i;

  always_comb begin
    dims_ok = 1'b1;
    if (in_m == '0 || in_n == '0) dims_ok = 1'b0;
    if (k_m == '0 || k_n == '0) dims_ok = 1'b0;
    if (int'(in_m) > MAX_M || int'(in_n) > MAX_M) dims_ok = 1'b0;
    if (int'(k_m) > MAX_K || int'(k_n) > MAX_K) dims_ok = 1'b0;
    if (int'(in_m) < int'(k_m)) dims_ok = 1'b0;
    if (int'(in_n) < int'(k_n)) dims_ok = 1'b0;
  end

  always_comb begin
    px = img_r[((int'(i_r) + int'(ki_r)) * MAX_M
               + int'(j_r) + int'(kj_r)) * DW +: DW];
    kx = ker_r[(int'(ki_r) * MAX_K + int'(kj_r)) * DW +: DW];
    prod = px * kx;
    sum = acc + ACC_W'(prod);
    // Saturation compares the full-width sum, so no overflow is missed
    res = (sat_r && sum > SAT_MAX) ? '1 : sum[DW-1:0];
    last_kj = (kj_r == kn_r - KDIM_W'(1));
    last_ki = (ki_r == km_r - KDIM_W'(1));
    last_j  = (j_r == out_n - DIM_W'(1));
    last_i  = (i_r == out_m - DIM_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      img_r        <= '0;
      ker_r        <= '0;
      km_r         <= '0;
      kn_r         <= '0;
      sat_r        <= 1'b0;
      i_r          <= '0;
      j_r          <= '0;
      ki_r         <= '0;
      kj_r         <= '0;
      acc          <= '0;
      out_m        <= '0;
      out_n        <= '0;
      matrices_out <= '0;
      busy         <= 1'b0;
      valid        <= 1'b0;
      error        <= 1'b0;
      cycleCount   <= '0;
    end else begin
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            img_r        <= matrices_in;
            ker_r        <= kernelMatrix;
            km_r         <= k_m;
            kn_r         <= k_n;
            sat_r        <= sat_mode;
            i_r          <= '0;
            j_r          <= '0;
            ki_r         <= '0;
            kj_r         <= '0;
            acc          <= '0;
            matrices_out <= '0;
            valid        <= 1'b0;
            cycleCount   <= '0;
            if (dims_ok) begin
              out_m <= in_m - DIM_W'(k_m) + DIM_W'(1);
              out_n <= in_n - DIM_W'(k_n) + DIM_W'(1);
              busy  <= 1'b1;
              state <= COMPUTE;
            end else begin
              out_m <= '0;
              out_n <= '0;
              error <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          cycleCount <= cycleCount + 16'd1;
          if (!last_kj) begin
            kj_r <= kj_r + KDIM_W'(1);
            acc  <= sum;
          end else if (!last_ki) begin
            kj_r <= '0;
            ki_r <= ki_r + KDIM_W'(1);
            acc  <= sum;
          end else begin
            kj_r <= '0;
            ki_r <= '0;
            acc  <= '0;
            matrices_out[(int'(i_r) * MAX_M + int'(j_r)) * DW +: DW] <= res;
            if (!last_j) begin
              j_r <= j_r + DIM_W'(1);
            end else begin
              j_r <= '0;
              if (!last_i) begin
                i_r <= i_r + DIM_W'(1);
              end else begin
                i_r   <= '0;
                busy  <= 1'b0;
                valid <= 1'b1;
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_engine_seq.sv
// Scoreboard bench for conv_engine_seq: reference model, handshake,
// invalid-dimension, mid-job start and mid-job reset checks.
module tb_conv_engine_seq;

  localparam int MAX_M  = 5;
  localparam int MAX_K  = 3;
  localparam int DW     = 8;
  localparam int DIM_W  = 3;
  localparam int KDIM_W = 2;
  localparam int IW     = MAX_M * MAX_M * DW;
  localparam int KW     = MAX_K * MAX_K * DW;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [DIM_W-1:0]  in_m;
  logic [DIM_W-1:0]  in_n;
  logic [KDIM_W-1:0] k_m;
  logic [KDIM_W-1:0] k_n;
  logic              sat_mode;
  logic [IW-1:0]     matrices_in;
  logic [KW-1:0]     kernelMatrix;
  logic [DIM_W-1:0]  out_m;
  logic [DIM_W-1:0]  out_n;
  logic [IW-1:0]     matrices_out;
  logic              busy;
  logic              valid;
  logic              error;
  logic [15:0]       cycleCount;

  conv_engine_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_m        (in_m),
    .in_n        (in_n),
    .k_m         (k_m),
    .k_n         (k_n),
    .sat_mode    (sat_mode),
    .matrices_in (matrices_in),
    .kernelMatrix(kernelMatrix),
    .out_m       (out_m),
    .out_n       (out_n),
    .matrices_out(matrices_out),
    .busy        (busy),
    .valid       (valid),
    .error       (error),
    .cycleCount  (cycleCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            om;
    int            on;
    int            cyc;
    logic [IW-1:0] mat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(string tag, logic [IW-1:0] got, logic [IW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(int im, int in_, int km, int kn, bit sat,
                                 logic [IW-1:0] img, logic [KW-1:0] ker);
    exp_t e;
    e.om  = im - km + 1;
    e.on  = in_ - kn + 1;
    e.cyc = e.om * e.on * km * kn;
    e.mat = '0;
    for (int r = 0; r < e.om; r++) begin
      for (int c = 0; c < e.on; c++) begin
        int s;
        int v;
        s = 0;
        for (int a = 0; a < km; a++)
          for (int b = 0; b < kn; b++)
            s += int'(img[((r + a) * MAX_M + c + b) * DW +: DW])
               * int'(ker[(a * MAX_K + b) * DW +: DW]);
        v = sat ? ((s > 255) ? 255 : s) : (s % 256);
        e.mat[(r * MAX_M + c) * DW +: DW] = 8'(v);
      end
    end
    return e;
  endfunction

  task automatic scramble_inputs();
    for (int b = 0; b < MAX_M * MAX_M; b++)
      matrices_in[b * DW +: DW] = 8'($urandom_range(0, 255));
    for (int b = 0; b < MAX_K * MAX_K; b++)
      kernelMatrix[b * DW +: DW] = 8'($urandom_range(0, 255));
    in_m = 3'd0;
    in_n = 3'd0;
    k_m = 2'd0;
    k_n = 2'd0;
    sat_mode = ~sat_mode;
  endtask

  task automatic run_job(int im, int in_, int km, int kn, bit sat,
                         logic [IW-1:0] img, logic [KW-1:0] ker, bit mid);
    int   cnt;
    bit   done;
    exp_t e;
    @(negedge clk);
    in_m = DIM_W'(im);
    in_n = DIM_W'(in_);
    k_m = KDIM_W'(km);
    k_n = KDIM_W'(kn);
    sat_mode = sat;
    matrices_in = img;
    kernelMatrix = ker;
    start = 1'b1;
    sb.push_back(model(im, in_, km, kn, sat, img, ker));
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    check("busy_rise", busy, 1'b1);
    cnt = busy ? 1 : 0;
    done = 1'b0;
    for (int g = 0; g < 200 && !done; g++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid) begin
        done = 1'b1;
      end else begin
        if (busy) cnt++;
        if (mid && cnt == 5) begin
          in_m = 3'd4;
          in_n = 3'd4;
          k_m = 2'd2;
          k_n = 2'd2;
          start = 1'b1;
        end
      end
    end
    start = 1'b0;
    if (!done) begin
      check("valid_timeout", 1'b0, 1'b1);
      sb.delete();
    end else begin
      e = sb.pop_front();
      check("busy_cycles", cnt, e.cyc);
      check("busy_fall", busy, 1'b0);
      check("out_m", out_m, e.om);
      check("out_n", out_n, e.on);
      check("cycleCount", cycleCount, e.cyc);
      check("result", matrices_out, e.mat);
      repeat (3) @(negedge clk);
      check("valid_hold", valid, 1'b1);
      check("result_hold", matrices_out, e.mat);
    end
  endtask

  task automatic run_invalid(int im, int in_, int km, int kn);
    @(negedge clk);
    in_m = DIM_W'(im);
    in_n = DIM_W'(in_);
    k_m = KDIM_W'(km);
    k_n = KDIM_W'(kn);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", error, 1'b1);
    check("err_busy", busy, 1'b0);
    check("err_valid", valid, 1'b0);
    check("err_out_m", out_m, 0);
    check("err_out_n", out_n, 0);
    check("err_result", matrices_out, '0);
    check("err_cyc", cycleCount, 0);
    @(negedge clk);
    check("err_drop", error, 1'b0);
    check("err_busy2", busy, 1'b0);
  endtask

  task automatic check_all_zero(string pfx);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_valid"}, valid, 1'b0);
    check({pfx, "_error"}, error, 1'b0);
    check({pfx, "_out_m"}, out_m, 0);
    check({pfx, "_out_n"}, out_n, 0);
    check({pfx, "_result"}, matrices_out, '0);
    check({pfx, "_cyc"}, cycleCount, 0);
  endtask

  logic [IW-1:0] img;
  logic [KW-1:0] ker;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_m = '0;
    in_n = '0;
    k_m = '0;
    k_n = '0;
    sat_mode = 1'b0;
    matrices_in = '0;
    kernelMatrix = '0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b0;

    // all-ones 5x5 by 3x3, with a start reasserted mid-job
    img = '0;
    for (int b = 0; b < 25; b++) img[b * DW +: DW] = 8'd1;
    ker = '0;
    for (int b = 0; b < 9; b++) ker[b * DW +: DW] = 8'd1;
    run_job(5, 5, 3, 3, 1'b0, img, ker, 1'b1);

    // wrap versus saturate
    img = '0;
    for (int b = 0; b < 25; b++) img[b * DW +: DW] = 8'd200;
    ker = '0;
    ker[7:0] = 8'd2;
    run_job(2, 2, 1, 1, 1'b0, img, ker, 1'b0);
    run_job(2, 2, 1, 1, 1'b1, img, ker, 1'b0);

    // non-square 4x3 image, diagonal 2x2 kernel
    img = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        img[(r * MAX_M + c) * DW +: DW] = 8'(r * 3 + c);
    ker = '0;
    ker[0 * DW +: DW] = 8'd1;
    ker[4 * DW +: DW] = 8'd1;
    run_job(4, 3, 2, 2, 1'b0, img, ker, 1'b0);
    check("nonsq_lit", matrices_out[(2 * MAX_M + 1) * DW +: DW], 8'd18);

    run_invalid(1, 3, 2, 1);
    run_invalid(6, 3, 2, 1);
    run_invalid(3, 3, 0, 2);

    // reset in the middle of a job
    img = '0;
    for (int b = 0; b < 25; b++) img[b * DW +: DW] = 8'd3;
    @(negedge clk);
    in_m = 3'd5;
    in_n = 3'd5;
    k_m = 2'd3;
    k_n = 2'd3;
    matrices_in = img;
    kernelMatrix = ker;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    reset = 1'b0;

    // random job with saturation after the aborted one
    for (int b = 0; b < 25; b++) img[b * DW +: DW] = 8'($urandom_range(0, 255));
    ker = '0;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 3; b++)
        ker[(a * MAX_K + b) * DW +: DW] = 8'($urandom_range(0, 40));
    run_job(5, 4, 2, 3, 1'b1, img, ker, 1'b0);
    run_job(3, 5, 3, 2, 1'b0, img, ker, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
